// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Initiator side of a 16-point FFT frame interface. The loader collects
// signed audio samples into two ping-pong banks. It hands each full bank to
// the FFT in parallel, pulses start, and holds the bank stable until the FFT
// reports done. Capture into the other bank continues meanwhile.
// Optional feature macro: FFT_LOADER_TIMEOUT_EN. When it is defined, a frame
// is abandoned if done does not arrive within TIMEOUT cycles of start.

module fft_frame_loader #(
   parameter int FRAME_LEN = 16,
   parameter int DW        = 16,
   parameter int TIMEOUT   = 256
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic signed [DW-1:0]           i_sample,
   input  logic                           i_sample_valid,
   output logic                           o_sample_ready,
   output logic [FRAME_LEN-1:0][DW-1:0]   o_frame,
   output logic                           o_fft_start,
   input  logic                           i_fft_done,
   output logic                           o_busy,
   output logic [15:0]                    o_frame_cnt,
   output logic                           o_timeout
);

   localparam int PW = $clog2(FRAME_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_WAIT,
      S_RELEASE
   } state_t;

   state_t state;
   state_t state_next;

   logic [FRAME_LEN-1:0][DW-1:0] bank [2];
   logic [1:0]                   full;
   logic [PW-1:0]                wr_ptr;
   logic                         wr_bank;
   logic                         rd_bank;
   logic                         take;
   logic                         last_write;
   logic                         release_bank;
   logic                         count_frame;
   logic                         tmo_expired;

   // The loader stalls the source only when the bank it would write next is
   // still waiting on the FFT, which happens only when both banks are full.
   assign o_sample_ready = !full[wr_bank];
   assign take           = i_sample_valid && o_sample_ready;
   assign last_write     = (wr_ptr == PW'(FRAME_LEN - 1));

   // The FFT always sees the read bank. That bank is never written while it is full.
   assign o_frame = bank[rd_bank];

`ifdef FFT_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;
   logic          tmo_q;

   // Count the cycles elapsed since start while the FFT owns the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == S_START) begin
         wait_cnt <= TW'(1);
      end else if (state == S_ARM || state == S_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // A timeout fires only when a genuine done is not arriving on that same cycle.
   assign tmo_expired = (state == S_ARM || state == S_WAIT) &&
                        (wait_cnt == TW'(TIMEOUT - 1)) &&
                        !(state == S_WAIT && i_fft_done);

   // Remember that this release is an abandonment, so that it pulses o_timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= tmo_expired;
      end
   end

   assign o_timeout   = tmo_q;
   assign count_frame = release_bank && !tmo_q;
`else
   assign tmo_expired = 1'b0;
   assign o_timeout   = 1'b0;
   assign count_frame = release_bank;
`endif

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Issue sequencing. ARM waits out the done level left high by the
   // previous frame, so that only a fresh done releases the bank.
   always_comb begin
      state_next   = state;
      o_fft_start  = 1'b0;
      o_busy       = 1'b0;
      release_bank = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (full[rd_bank]) begin
               state_next = S_START;
            end
         end
         S_START: begin
            o_fft_start = 1'b1;
            o_busy      = 1'b1;
            state_next  = S_ARM;
         end
         S_ARM: begin
            o_busy = 1'b1;
            if (tmo_expired) begin
               state_next = S_RELEASE;
            end else if (!i_fft_done) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            o_busy = 1'b1;
            if (i_fft_done || tmo_expired) begin
               state_next = S_RELEASE;
            end
         end
         S_RELEASE: begin
            release_bank = 1'b1;
            state_next   = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Bank storage, fill bookkeeping and frame counter. A release and the
   // final write into the other bank may land on the same edge, and both take effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank[0]     <= '0;
         bank[1]     <= '0;
         full        <= 2'b00;
         wr_ptr      <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         o_frame_cnt <= 16'd0;
      end else begin
         if (take) begin
            bank[wr_bank][wr_ptr] <= i_sample;
            if (last_write) begin
               full[wr_bank] <= 1'b1;
               wr_ptr        <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
         if (release_bank) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
         if (count_frame) begin
            o_frame_cnt <= o_frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader.
// It covers fill and issue, ping-pong back-pressure, a stale done level,
// a release that coincides with the last write, and reset mid-frame.
// When FFT_LOADER_TIMEOUT_EN is defined it also covers the abandon path.

module tb_fft_frame_loader;

   localparam int FRAME_LEN = 16;
   localparam int DW        = 16;

   logic                         clk = 1'b0;
   logic                         rst;
   logic signed [DW-1:0]         i_sample;
   logic                         i_sample_valid;
   logic                         o_sample_ready;
   logic [FRAME_LEN-1:0][DW-1:0] o_frame;
   logic                         o_fft_start;
   logic                         i_fft_done;
   logic                         o_busy;
   logic [15:0]                  o_frame_cnt;
   logic                         o_timeout;

   int checks   = 0;
   int failures = 0;

   fft_frame_loader #(
      .FRAME_LEN (FRAME_LEN),
      .DW        (DW),
      .TIMEOUT   (256)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .o_frame        (o_frame),
      .o_fft_start    (o_fft_start),
      .i_fft_done     (i_fft_done),
      .o_busy         (o_busy),
      .o_frame_cnt    (o_frame_cnt),
      .o_timeout      (o_timeout)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample and let the next edge take it.
   task automatic applyStimulus(input logic valid, input logic [DW-1:0] sample);
      i_sample_valid = valid;
      i_sample       = sample;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkFrame(input string tag, input logic [FRAME_LEN*DW-1:0] observed,
                             input logic [FRAME_LEN*DW-1:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // The expected frame for a run of consecutive samples starting at base.
   // Index 0 holds the oldest sample.
   function automatic logic [FRAME_LEN*DW-1:0] rampFrame(input logic [DW-1:0] base);
      logic [FRAME_LEN*DW-1:0] f;
      f = '0;
      for (int k = 0; k < FRAME_LEN; k++) begin
         f[k*DW +: DW] = base + DW'(k);
      end
      return f;
   endfunction

   // Feed a full frame of consecutive samples, then drop valid.
   task automatic feedFrame(input logic [DW-1:0] base, input int count);
      for (int k = 0; k < count; k++) begin
         applyStimulus(1'b1, base + DW'(k));
      end
      i_sample_valid = 1'b0;
   endtask

   // Bounded wait for the start pulse. It reports how many clocks it took.
   task automatic waitForStart(input string tag, input int limit, output int waited);
      waited = 0;
      while (!o_fft_start && waited < limit) begin
         tick();
         waited++;
      end
      checkOutput({tag, "_start_seen"}, 32'(o_fft_start), 32'd1);
   endtask

   initial begin
      int w;
      int sent;
      int frames;
      int startCyc;
      int firstDrop;
      logic [DW-1:0] base;
      logic prevReady;
      logic [15:0] prevCnt;

      rst            = 1'b1;
      i_sample       = '0;
      i_sample_valid = 1'b0;
      i_fft_done     = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_ready", 32'(o_sample_ready), 32'd1);
      checkOutput("rst_start", 32'(o_fft_start), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_cnt", 32'(o_frame_cnt), 32'd0);
      checkOutput("rst_timeout", 32'(o_timeout), 32'd0);
      checkFrame("rst_frame", o_frame, '0);

      $display("[TB] single frame, samples 1..16");
      feedFrame(16'd1, 16);
      checkOutput("t1_no_early_start", 32'(o_fft_start), 32'd0);
      checkOutput("t1_ready_other_bank", 32'(o_sample_ready), 32'd1);
      tick();
      checkOutput("t1_start_latency", 32'(o_fft_start), 32'd1);
      checkOutput("t1_busy_at_start", 32'(o_busy), 32'd1);
      checkFrame("t1_frame", o_frame, rampFrame(16'd1));
      tick();
      checkOutput("t1_start_one_cycle", 32'(o_fft_start), 32'd0);
      checkOutput("t1_busy_in_arm", 32'(o_busy), 32'd1);
      repeat (19) tick();
      checkOutput("t1_still_waiting", 32'(o_busy), 32'd1);
      checkOutput("t1_cnt_before_done", 32'(o_frame_cnt), 32'd0);
      i_fft_done = 1'b1;
      tick();
      checkOutput("t1_busy_in_release", 32'(o_busy), 32'd0);
      checkFrame("t1_frame_held", o_frame, rampFrame(16'd1));
      tick();
      checkOutput("t1_cnt_after", 32'(o_frame_cnt), 32'd1);
      checkOutput("t1_busy_after", 32'(o_busy), 32'd0);

      $display("[TB] continuous 48 samples, done 100 cycles after each start");
      sent      = 0;
      frames    = 0;
      base      = 16'd1;
      startCyc  = -1;
      firstDrop = -1;
      prevReady = o_sample_ready;
      prevCnt   = o_frame_cnt;
      for (int cyc = 0; cyc < 800 && frames < 3; cyc++) begin
         if (o_fft_start) begin
            checkFrame($sformatf("t2_frame%0d", frames), o_frame, rampFrame(base));
            base       = base + 16'd16;
            startCyc   = cyc;
            i_fft_done = 1'b0;
         end else if (startCyc >= 0 && cyc == startCyc + 100) begin
            i_fft_done = 1'b1;
         end
         if (!o_sample_ready && prevReady && firstDrop < 0) begin
            firstDrop = sent;
            checkOutput("t2_ready_drop_at", 32'(sent), 32'd32);
         end
         if (o_sample_ready && !prevReady) begin
            checkOutput("t2_ready_rise_on_release", 32'(o_frame_cnt), 32'(16'(prevCnt + 16'd1)));
         end
         if (o_frame_cnt != prevCnt) begin
            frames++;
         end
         prevReady      = o_sample_ready;
         prevCnt        = o_frame_cnt;
         i_sample_valid = (sent < 48);
         i_sample       = 16'(sent + 1);
         if (i_sample_valid && o_sample_ready) begin
            sent++;
         end
         tick();
      end
      i_sample_valid = 1'b0;
      checkOutput("t2_frames_done", 32'(frames), 32'd3);
      checkOutput("t2_all_samples_taken", 32'(sent), 32'd48);
      checkOutput("t2_ready_dropped", 32'(firstDrop >= 0), 32'd1);
      checkOutput("t2_cnt", 32'(o_frame_cnt), 32'd4);

      $display("[TB] stale done level held across start");
      feedFrame(16'd100, 16);
      waitForStart("t3", 5, w);
      checkOutput("t3_start_latency", 32'(w), 32'd1);
      checkFrame("t3_frame", o_frame, rampFrame(16'd100));
      tick();
      tick();
      checkOutput("t3_stale_done_busy", 32'(o_busy), 32'd1);
      checkOutput("t3_stale_done_cnt", 32'(o_frame_cnt), 32'd4);
      i_fft_done = 1'b0;
      repeat (27) tick();
      checkOutput("t3_wait_busy", 32'(o_busy), 32'd1);
      checkOutput("t3_wait_cnt", 32'(o_frame_cnt), 32'd4);
      i_fft_done = 1'b1;
      tick();
      checkOutput("t3_release_busy", 32'(o_busy), 32'd0);
      tick();
      checkOutput("t3_cnt_after", 32'(o_frame_cnt), 32'd5);
      repeat (3) tick();
      checkOutput("t3_single_increment", 32'(o_frame_cnt), 32'd5);

      $display("[TB] release coincides with last write to the other bank");
      feedFrame(16'd200, 16);
      waitForStart("t4d", 5, w);
      checkFrame("t4_frame_d", o_frame, rampFrame(16'd200));
      i_fft_done = 1'b0;
      feedFrame(16'h8000, 15);
      i_fft_done = 1'b1;
      tick();
      checkOutput("t4_in_release", 32'(o_busy), 32'd0);
      applyStimulus(1'b1, 16'h800F);
      i_sample_valid = 1'b0;
      checkOutput("t4_no_early_start", 32'(o_fft_start), 32'd0);
      checkOutput("t4_cnt", 32'(o_frame_cnt), 32'd6);
      checkOutput("t4_ready", 32'(o_sample_ready), 32'd1);
      tick();
      checkOutput("t4_start_latency", 32'(o_fft_start), 32'd1);
      checkFrame("t4_frame_e", o_frame, rampFrame(16'h8000));
      i_fft_done = 1'b0;

      $display("[TB] reset mid-wait with partial frame");
      feedFrame(16'd300, 8);
      checkOutput("t5_busy_before_rst", 32'(o_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5_ready", 32'(o_sample_ready), 32'd1);
      checkOutput("t5_start", 32'(o_fft_start), 32'd0);
      checkOutput("t5_busy", 32'(o_busy), 32'd0);
      checkOutput("t5_cnt", 32'(o_frame_cnt), 32'd0);
      checkOutput("t5_timeout", 32'(o_timeout), 32'd0);
      checkFrame("t5_frame_zero", o_frame, '0);
      feedFrame(16'd400, 16);
      waitForStart("t5", 5, w);
      checkOutput("t5_start_latency", 32'(w), 32'd1);
      checkFrame("t5_fresh_frame", o_frame, rampFrame(16'd400));
      repeat (5) tick();
      i_fft_done = 1'b1;
      tick();
      tick();
      checkOutput("t5_cnt_after", 32'(o_frame_cnt), 32'd1);

`ifdef FFT_LOADER_TIMEOUT_EN
      $display("[TB] timeout when done never rises");
      feedFrame(16'd500, 16);
      waitForStart("t6", 5, w);
      i_fft_done = 1'b0;
      w = 0;
      while (!o_timeout && w < 400) begin
         tick();
         w++;
      end
      checkOutput("t6_timeout_seen", 32'(o_timeout), 32'd1);
      checkOutput("t6_timeout_delay", 32'(w), 32'd256);
      tick();
      checkOutput("t6_timeout_one_cycle", 32'(o_timeout), 32'd0);
      checkOutput("t6_cnt_unchanged", 32'(o_frame_cnt), 32'd1);
      feedFrame(16'd600, 16);
      waitForStart("t6n", 5, w);
      checkFrame("t6_next_frame", o_frame, rampFrame(16'd600));
`else
      $display("[TB] no timeout in default build");
      checkOutput("t6_timeout_tied", 32'(o_timeout), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Initiator side of the 16-point FFT frame interface.
- Collects a serial stream of signed audio samples into 16-sample frames using ping-pong buffering.
- Presents a full frame in parallel to the FFT, pulses its start input, holds the frame stable until the FFT reports done, then frees the bank.
- Sits between the audio sample source and the FFT; capture continues while a transform is running.

Parameters:
FRAME_LEN, 16, samples per frame; must equal the FFT size (only 16 supported).
DW, 16, sample width in bits, signed two's complement.
TIMEOUT, 256, maximum wait cycles for FFT done; used only with FFT_LOADER_TIMEOUT_EN.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
i_sample  in  DW  signed input sample
i_sample_valid  in  1  sample present
o_sample_ready  out  1  loader can accept a sample
o_frame  out  FRAME_LEN x DW  frame to FFT, index 0 = oldest sample
o_fft_start  out  1  one-cycle start pulse to FFT
i_fft_done  in  1  FFT done flag; level signal that stays high until the next start is consumed
o_busy  out  1  a frame is in flight (start issued, done not yet seen)
o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0
o_timeout  out  1  one-cycle pulse on abandoned frame

Behaviour:
- Reset: single clock, synchronous active-high reset on rst. On reset:
  - o_sample_ready=1, o_fft_start=0, o_busy=0, o_frame_cnt=0, o_timeout=0.
  - Both bank full flags cleared; write pointer = 0; write and read bank select = bank 0.
  - Bank contents cleared to 0, so o_frame reads all zeros.
- Sample capture:
  - A handshake occurs when i_sample_valid && o_sample_ready at a clock edge.
  - The sample is written to the write bank at the write pointer, and the pointer increments.
  - On the FRAME_LEN-th write: the bank full flag is set, the pointer returns to 0, and the write bank toggles.
- o_sample_ready = !full[write bank], registered-equivalent: it is 0 only when both banks are full.
- While ready=0, samples are not taken; nothing is dropped silently.
- Issue FSM:
  - IDLE: if full[read bank] -> START.
  - START: o_fft_start=1 for exactly this cycle; o_busy=1 -> ARM.
  - ARM: wait for i_fft_done==0. This discards the stale done level left over from the previous frame. Then -> WAIT.
  - WAIT: on i_fft_done==1 -> RELEASE.
  - RELEASE: clear full[read bank], toggle read bank, increment o_frame_cnt, o_busy=0 -> IDLE.
- Latency: o_fft_start is high in the 2nd cycle after the cycle containing the 16th handshake, provided the FSM was IDLE.
- o_frame is muxed from the read bank. It must be stable from the START cycle through RELEASE. The write bank never equals the read bank while that bank is full.
- Frame ordering: banks fill and issue strictly alternately, so frames go out in arrival order.
- Simultaneous release and 16th write to the other bank are both honoured. The newly full bank issues after IDLE.
- A release while both banks are full raises o_sample_ready in the following cycle.
- Reset mid-operation aborts everything. Partially filled frames are lost. The FFT shares rst, so it restarts too.

Optional Feature:
- Macro: FFT_LOADER_TIMEOUT_EN.
- Defined:
  - A counter clears at START and counts each cycle in ARM/WAIT.
  - When it reaches TIMEOUT, the FSM goes to RELEASE without incrementing o_frame_cnt, and pulses o_timeout for one cycle.
  - The bank is freed and the next frame proceeds normally.
- Not defined: no counter; o_timeout tied 0; the FSM waits indefinitely.

Test Plan:
- Samples 1..16 on 16 consecutive cycles, done low -> o_fft_start pulse 2 cycles after the 16th; o_frame[k]=k+1; o_busy=1. Raise done after 20 cycles -> o_frame_cnt=1, o_busy=0.
- Continuous valid, 48 samples; done answered 100 cycles after each start:
  - ready drops after the 32nd handshake.
  - Frames issue in order: first sample 1, 17, 33.
  - Each ready drop lasts until the corresponding release; no sample is lost.
- i_fft_done held high (prior frame level) at START, falling 2 cycles later and rising 30 cycles later -> release only after the rise; o_frame_cnt increments once.
- Release of bank 0 on the same cycle as the 16th write to bank 1 -> bank 1 start 2 cycles later; o_frame shows bank 1 data.
- rst asserted for 1 cycle mid-WAIT with 8 samples in the write bank -> next cycle all outputs at reset values; the next 16 samples form a fresh frame.
- With FFT_LOADER_TIMEOUT_EN, TIMEOUT=256, done never rises -> o_timeout pulse 256 cycles after START; o_frame_cnt unchanged; next full frame issues.
